hazard_fwd_ctrl: RTL and testbench



---
 rtl/core_pkg.sv | 16 +
 rtl/fwd_sel_unit.sv | 25 ++
 rtl/hazard_fwd_ctrl.sv | 156 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the core's hazard/forwarding logic: forwarding mux
// codes, the hazard FSM state encoding and the architectural zero register.
package core_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding priority compare: picks the youngest in-flight
// producer of rs, or the register file when nothing matches.
module fwd_sel_unit
    import core_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] ex_rd,
    input  logic       ex_reg_write,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    output logic [1:0] sel
);

    // x0 is hardwired; a pending "write" to it must never be forwarded.
    always_comb begin
        sel = FWD_RF;
        if (rs != REG_ZERO) begin
            if (ex_reg_write && ex_rd == rs)
                sel = FWD_MEM;
            else if (mem_reg_write && mem_rd == rs)
                sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage core: shadow EX/MEM/WB destination
// tracking, registered forwarding selects, load-use stalls, branch flushes.
module hazard_fwd_ctrl
    import core_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_reg_write, mem_reg_write, wb_reg_write;
    logic       ex_mem_read, mem_mem_read, wb_mem_read;

    hz_state_e  state, next_state;
    logic [1:0] scnt, scnt_next;
    logic       stall_raw;
    logic       hazard;
    logic       id_ok;
    logic [1:0] sel_a, sel_b;

    assign hazard = id_valid && ex_mem_read && ex_reg_write && (ex_rd != REG_ZERO) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    always_comb begin
        next_state = state;
        scnt_next  = scnt;
        stall_raw  = 1'b0;
        if (ex_branch_taken) begin
            next_state = ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hazard) begin
                        stall_raw = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            next_state = ST_STALL;
                            scnt_next  = 2'(LU_STALL_CYCLES - 1);
                        end
                    end
                end
                ST_STALL: begin
                    stall_raw = 1'b1;
                    scnt_next = scnt - 2'd1;
                    if (scnt == 2'd1)
                        next_state = ST_RUN;
                end
                default: next_state = ST_RUN;
            endcase
        end
    end

    // Gated by rst_n so nothing leaks out while the core is held in reset.
    assign stall       = rst_n && stall_raw;
    assign flush_if_id = rst_n && ex_branch_taken;
    assign flush_id_ex = rst_n && ex_branch_taken;

    assign id_ok = id_valid && !stall && !flush_id_ex;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
            scnt  <= 2'd0;
        end else begin
            state <= next_state;
            scnt  <= scnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd         <= REG_ZERO;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_rd        <= REG_ZERO;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            wb_rd         <= REG_ZERO;
            wb_reg_write  <= 1'b0;
            wb_mem_read   <= 1'b0;
        end else begin
            if (id_ok) begin
                ex_rd        <= id_rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end else begin
                ex_rd        <= REG_ZERO;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
            end
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            wb_rd         <= mem_rd;
            wb_reg_write  <= mem_reg_write;
            wb_mem_read   <= mem_mem_read;
        end
    end

    fwd_sel_unit u_fwd_a (
        .rs            (id_rs1),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .sel           (sel_a)
    );

    fwd_sel_unit u_fwd_b (
        .rs            (id_rs2),
        .ex_rd         (ex_rd),
        .ex_reg_write  (ex_reg_write),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .sel           (sel_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_sel <= FWD_RF;
            fwd_b_sel <= FWD_RF;
        end else begin
            fwd_a_sel <= id_ok ? sel_a : FWD_RF;
            fwd_b_sel <= id_ok ? sel_b : FWD_RF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (ex_branch_taken && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench: two instances share stimulus, u0 (1-cycle load-use, 32-bit
// counters) and u1 (3-cycle load-use, 4-bit counters).
module tb_hazard_fwd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_valid, id_reg_write, id_mem_read, ex_branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
    logic        a_stall, a_fif, a_fie, b_stall, b_fif, b_fie;
    logic [31:0] a_scnt, a_fcnt;
    logic [3:0]  b_scnt, b_fcnt;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(32)) u0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .fwd_a_sel(a_fwd_a), .fwd_b_sel(a_fwd_b),
        .stall(a_stall), .flush_if_id(a_fif), .flush_id_ex(a_fie),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

    hazard_fwd_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .fwd_a_sel(b_fwd_a), .fwd_b_sel(b_fwd_b),
        .stall(b_stall), .flush_if_id(b_fif), .flush_id_ex(b_fie),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input logic rw, input logic mr, input logic br);
        id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rd = rd;
        id_reg_write = rw; id_mem_read = mr; ex_branch_taken = br;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle();
        repeat (3) adv();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        adv();
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset: branch driven high to show flushes are masked in reset.
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rst_fwd_a", 32'(a_fwd_a), 0);
        chk("rst_fwd_b", 32'(a_fwd_b), 0);
        chk("rst_stall", 32'(a_stall), 0);
        chk("rst_flush_if_id", 32'(a_fif), 0);
        chk("rst_flush_id_ex", 32'(a_fie), 0);
        chk("rst_stall_cnt", a_scnt, 0);
        chk("rst_flush_cnt", a_fcnt, 0);
        adv();
        rst_n = 1'b1;
        drain();

        // Back-to-back ALU: add x5 ; sub x8,x5,x6
        drv(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk("b2b_prod_stall", 32'(a_stall), 0); adv();
        drv(1'b1, 5'd5, 5'd6, 5'd8, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk("b2b_cons_stall", 32'(a_stall), 0); adv();
        idle();
        @(negedge clk);
        chk("b2b_fwd_a", 32'(a_fwd_a), 1);
        chk("b2b_fwd_b", 32'(a_fwd_b), 0);
        adv(); drain();

        // Distance 2 on rs2
        drv(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0); adv();
        drv(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0); adv();
        drv(1'b1, 5'd3, 5'd7, 5'd12, 1'b1, 1'b0, 1'b0); adv();
        idle();
        @(negedge clk);
        chk("d2_fwd_b", 32'(a_fwd_b), 2);
        chk("d2_fwd_a", 32'(a_fwd_a), 0);
        adv(); drain();

        // Distance 3: write-through register file, no forwarding
        drv(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0); adv();
        drv(1'b1, 5'd1, 5'd2, 5'd10, 1'b1, 1'b0, 1'b0); adv();
        drv(1'b1, 5'd1, 5'd2, 5'd11, 1'b1, 1'b0, 1'b0); adv();
        drv(1'b1, 5'd3, 5'd7, 5'd12, 1'b1, 1'b0, 1'b0); adv();
        idle();
        @(negedge clk); chk("d3_fwd_b", 32'(a_fwd_b), 0);
        adv(); drain();

        // Load-use: lw x3 ; add x4,x3,x3 (held in ID while u1 stalls)
        do_reset();
        drv(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0);
        @(negedge clk); chk("lu_load_stall", 32'(a_stall), 0); adv();
        drv(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk("lu_u0_stall_c1", 32'(a_stall), 1);
        chk("lu_u1_stall_c1", 32'(b_stall), 1);
        adv();
        @(negedge clk);
        chk("lu_u0_stall_c2", 32'(a_stall), 0);
        chk("lu_u1_stall_c2", 32'(b_stall), 1);
        chk("lu_u0_bubble_fwd", 32'(a_fwd_a), 0);
        chk("lu_u0_stall_cnt", a_scnt, 1);
        adv();
        @(negedge clk);
        chk("lu_u0_fwd_a", 32'(a_fwd_a), 2);
        chk("lu_u0_fwd_b", 32'(a_fwd_b), 2);
        chk("lu_u0_no_restall", 32'(a_stall), 0);
        chk("lu_u1_stall_c3", 32'(b_stall), 1);
        adv();
        @(negedge clk);
        chk("lu_u1_stall_c4", 32'(b_stall), 0);
        chk("lu_u1_stall_cnt", 32'(b_scnt), 3);
        chk("lu_u0_stall_cnt_hold", a_scnt, 1);
        adv();
        idle();
        @(negedge clk);
        chk("lu_u1_fwd_a", 32'(b_fwd_a), 0);
        chk("lu_u1_fwd_b", 32'(b_fwd_b), 0);
        adv(); drain();

        // x0 never forwards or stalls, even with a pending load to x0
        drv(1'b1, 5'd1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); adv();
        drv(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk("x0_stall", 32'(a_stall), 0); adv();
        idle();
        @(negedge clk);
        chk("x0_fwd_a", 32'(a_fwd_a), 0);
        chk("x0_fwd_b", 32'(a_fwd_b), 0);
        adv(); drain();

        // x9 in both EX and MEM: EX wins
        drv(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0); adv();
        drv(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b0); adv();
        drv(1'b1, 5'd9, 5'd9, 5'd13, 1'b1, 1'b0, 1'b0); adv();
        idle();
        @(negedge clk);
        chk("pri_fwd_a", 32'(a_fwd_a), 1);
        chk("pri_fwd_b", 32'(a_fwd_b), 1);
        adv(); drain();

        // Hazard and taken branch in the same cycle: flush wins
        do_reset();
        drv(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0); adv();
        drv(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("sim_u0_stall", 32'(a_stall), 0);
        chk("sim_u1_stall", 32'(b_stall), 0);
        chk("sim_flush_if_id", 32'(a_fif), 1);
        chk("sim_flush_id_ex", 32'(a_fie), 1);
        adv();
        idle();
        @(negedge clk);
        chk("sim_u1_run", 32'(b_stall), 0);
        chk("sim_flush_off", 32'(a_fif), 0);
        chk("sim_flush_cnt", a_fcnt, 1);
        chk("sim_u0_stall_cnt", a_scnt, 0);
        chk("sim_u1_stall_cnt", 32'(b_scnt), 0);
        chk("sim_fwd_a", 32'(a_fwd_a), 0);
        adv(); drain();

        // Reset asserted while u1 is in its stall sequence
        drv(1'b1, 5'd2, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0); adv();
        drv(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk("rs_u1_stall_c1", 32'(b_stall), 1); adv();
        #2;
        rst_n = 1'b0;
        drv(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b1);
        #1;
        chk("rs_u1_stall", 32'(b_stall), 0);
        chk("rs_u1_flush_if_id", 32'(b_fif), 0);
        chk("rs_u1_flush_id_ex", 32'(b_fie), 0);
        chk("rs_u1_stall_cnt", 32'(b_scnt), 0);
        adv();
        rst_n = 1'b1;
        drv(1'b1, 5'd3, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk); chk("rs_u1_no_residual", 32'(b_stall), 0);
        adv();

        // 20 taken-branch cycles: 4-bit counter saturates at 15
        drv(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (20) adv();
        idle();
        @(negedge clk);
        chk("sat_u1_flush_cnt", 32'(b_fcnt), 15);
        chk("sat_u0_flush_cnt", a_fcnt, 20);
        chk("sat_u1_stall_cnt", 32'(b_scnt), 0);
        adv();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
